// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, types and helpers for the clock divider bank
// Channel FSM encoding and the derived channel-index width live here.
package clk_div_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int DIV_INIT_DEF = 1;

  typedef logic [CNT_W_DEF-1:0] div_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } ch_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - divide-code configuration request port
// The master drives a channel index and divide code; the slave answers with ready.
interface clk_div_bank_if import clk_div_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);

  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [CH_W-1:0]  cfg_ch_i;
  logic [CNT_W-1:0] cfg_div_i;

  modport master (
    output cfg_valid_i,
    output cfg_ch_i,
    output cfg_div_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_ch_i,
    input  cfg_div_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one runtime-programmable 50%-duty clock divider channel
// A loaded divide code waits in a shadow register until the falling toggle or idle.
module clk_div_ch import clk_div_pkg::*; #(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_div_i,
  output logic             div_clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             pending_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             active;
  logic             terminal;
  logic             apply;

  // A high half always runs to completion, even once en_i has dropped.
  assign active   = en_i || (state_q == ST_HIGH);
  assign terminal = active && (cnt_q == div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= CNT_W'(DIV_INIT);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOW: begin
        if (!en_i)         state_d = ST_IDLE;
        else if (terminal) state_d = ST_HIGH;
        else               state_d = ST_LOW;
      end
      ST_HIGH: begin
        if (terminal) state_d = en_i ? ST_LOW : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (active && !terminal) cnt_d = cnt_q + CNT_W'(1);
    rise_d   = terminal && (state_q != ST_HIGH);
    fall_d   = terminal && (state_q == ST_HIGH);
    // The falling toggle is the period boundary; an inactive channel has no period to protect.
    apply    = pend_q && (fall_d || !active);
    div_d    = apply ? shadow_q : div_q;
    shadow_d = load_i ? load_div_i : shadow_q;
    pend_d   = load_i || (pend_q && !apply);
  end

  assign div_clk_o = (state_q == ST_HIGH);
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independent clock divider channels with a shared config port
// Out-of-range channel writes are accepted and dropped.
module clk_div_bank import clk_div_pkg::*; #(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = CNT_W_DEF,
  parameter int  DIV_INIT = DIV_INIT_DEF,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_i,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] div_clk_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] pending_o
);

  localparam int NSLOT = 1 << CH_W;

  logic [NSLOT-1:0] pend_pad;
  logic             ready;
  logic             accept;

  // Unused index slots read as not-pending, so out-of-range writes see ready=1.
  assign pend_pad        = NSLOT'(pending_o);
  assign ready           = !rst && !pend_pad[cfg.cfg_ch_i];
  assign accept          = cfg.cfg_valid_i && ready;
  assign cfg.cfg_ready_o = ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i[i]),
      .load_i     (accept && (cfg.cfg_ch_i == CH_W'(i))),
      .load_div_i (cfg.cfg_div_i),
      .div_clk_o  (div_clk_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .pending_o  (pending_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank
// Five channels so that index 5 is representable and out of range.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NUM_CH   = 5;
  localparam int CNT_W    = 8;
  localparam int DIV_INIT = 1;

  typedef struct {
    int         ch;
    logic [3:0] bits;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en_i;
  logic [NUM_CH-1:0] div_clk_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic [NUM_CH-1:0] pending_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  clk_div_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .cfg       (cfg_if.slave),
    .div_clk_o (div_clk_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected {div_clk, rise, fall, pending} k edges after enable with constant code d.
  function automatic logic [3:0] exp_bits(input int k, input int d, input logic pend);
    int h;
    int p;
    logic [3:0] r;
    h = d + 1;
    r = {3'b000, pend};
    if (k >= d) begin
      p = (k - d) % (2 * h);
      r[3] = (p < h);
      r[2] = (p == 0);
      r[1] = (p == h);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    en_i               = '0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ch_i    = '0;
    cfg_if.cfg_div_i   = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    en_i               = '0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ch_i    = '0;
    cfg_if.cfg_div_i   = '0;
    tick();
    tick();
    checks++;
    if ({div_clk_o, rise_o, fall_o, pending_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {div_clk_o, rise_o, fall_o, pending_o});
    end
    checks++;
    if (cfg_if.cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low got=%b exp=0", cfg_if.cfg_ready_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_if.cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_release got=%b exp=1", cfg_if.cfg_ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (div_clk_o !== '0) begin
        failures++;
        $display("FAIL idle_hold k=%0d got=%b exp=0", k, div_clk_o);
      end
    end
  endtask

  task automatic test_basic();
    exp_t       e;
    logic [3:0] got;
    do_reset();
    en_i[0] = 1'b1;
    for (int k = 0; k < 13; k++) sb.push_back('{0, exp_bits(k, DIV_INIT, 1'b0)});
    for (int k = 0; k < 13; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL basic ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
    end
  endtask

  task automatic test_ratio_change();
    exp_t       e;
    logic [3:0] got;
    logic [3:0] b;
    int         p;
    do_reset();
    en_i[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k < 3) begin
        b = exp_bits(k, 1, k == 2);
      end else begin
        p = (k - 3) % 10;
        b = {p >= 5, p == 5, p == 0, 1'b0};
      end
      sb.push_back('{0, b});
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL ratio_change ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
      checks++;
      if (cfg_if.cfg_ready_o !== (k != 2)) begin
        failures++;
        $display("FAIL ratio_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready_o, k != 2);
      end
      if (k == 1) begin
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_ch_i    = 3'd0;
        cfg_if.cfg_div_i   = 8'd4;
      end
      if (k == 2) cfg_if.cfg_valid_i = 1'b0;
    end
  endtask

  task automatic test_idle_apply();
    exp_t       e;
    logic [3:0] got;
    do_reset();
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ch_i    = 3'd2;
    cfg_if.cfg_div_i   = 8'd0;
    tick();
    checks++;
    if (pending_o[2] !== 1'b1 || cfg_if.cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_pending_set got=%b%b exp=10", pending_o[2], cfg_if.cfg_ready_o);
    end
    cfg_if.cfg_valid_i = 1'b0;
    tick();
    checks++;
    if (pending_o[2] !== 1'b0 || cfg_if.cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL idle_pending_clear got=%b%b exp=01", pending_o[2], cfg_if.cfg_ready_o);
    end
    en_i[2] = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back('{2, exp_bits(k, 0, 1'b0)});
    for (int k = 0; k < 8; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL div2 ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
    end
  endtask

  task automatic test_disable_high();
    exp_t       e;
    logic [3:0] got;
    do_reset();
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ch_i    = 3'd1;
    cfg_if.cfg_div_i   = 8'd2;
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    tick();
    en_i[1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 2)                sb.push_back('{1, 4'b1100});
      else if (k == 3 || k == 4) sb.push_back('{1, 4'b1000});
      else if (k == 5)           sb.push_back('{1, 4'b0010});
      else                       sb.push_back('{1, 4'b0000});
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL disable_high ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
      if (k == 2) en_i[1] = 1'b0;
    end
  endtask

  task automatic test_out_of_range_concurrent();
    exp_t       e;
    logic [3:0] got;
    do_reset();
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ch_i    = 3'd5;
    cfg_if.cfg_div_i   = 8'd9;
    #1;
    checks++;
    if (cfg_if.cfg_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL oor_ready got=%b exp=1", cfg_if.cfg_ready_o);
    end
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    checks++;
    if (pending_o !== '0 || div_clk_o !== '0) begin
      failures++;
      $display("FAIL oor_no_effect got=%b/%b exp=0/0", pending_o, div_clk_o);
    end
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ch_i    = 3'd1;
    cfg_if.cfg_div_i   = 8'd2;
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    tick();
    en_i[0] = 1'b1;
    en_i[1] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      sb.push_back('{0, exp_bits(k, 1, 1'b0)});
      sb.push_back('{1, exp_bits(k, 2, 1'b0)});
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      for (int j = 0; j < 2; j++) begin
        e   = sb.pop_front();
        got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
        checks++;
        if (got !== e.bits) begin
          failures++;
          $display("FAIL concurrent ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
        end
      end
    end
  endtask

  task automatic test_reset_mid_high();
    exp_t       e;
    logic [3:0] got;
    do_reset();
    en_i[3] = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{3, exp_bits(k, 1, k == 2)});
    for (int k = 0; k < 3; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL pre_reset ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
      if (k == 1) begin
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_ch_i    = 3'd3;
        cfg_if.cfg_div_i   = 8'd7;
      end
    end
    cfg_if.cfg_valid_i = 1'b0;
    rst     = 1'b1;
    en_i    = '0;
    tick();
    checks++;
    if ({div_clk_o, rise_o, fall_o, pending_o} !== '0 || cfg_if.cfg_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b ready=%b exp=0 ready=0",
               {div_clk_o, rise_o, fall_o, pending_o}, cfg_if.cfg_ready_o);
    end
    rst     = 1'b0;
    en_i[3] = 1'b1;
    for (int k = 0; k < 10; k++) sb.push_back('{3, exp_bits(k, DIV_INIT, 1'b0)});
    for (int k = 0; k < 10; k++) begin
      tick();
      e   = sb.pop_front();
      got = {div_clk_o[e.ch], rise_o[e.ch], fall_o[e.ch], pending_o[e.ch]};
      checks++;
      if (got !== e.bits) begin
        failures++;
        $display("FAIL post_reset ch%0d k=%0d got=%b exp=%b", e.ch, k, got, e.bits);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ratio_change();
    test_idle_apply();
    test_disable_high();
    test_out_of_range_concurrent();
    test_reset_mid_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
